// File: rtl/alu_decode_stage.sv
// -----------------------------------------------------------------------------
// alu_decode_stage
//
// Purpose:
//   Decodes RISC-V style ALU control from ALUOp/op/funct3/funct7 and buffers
//   the result in a 2-entry FIFO between the decode and execute stages.
//   Unsupported encodings are forwarded as ADD with an illegal flag.
//   A saturating counter tracks how many illegal entries were accepted.
//
// Parameters:
//   CTRL_W  ALUControl width (>= 4). Bits above bit 3 are always 0.
//   EXT_EN  1: shift/SLT/SLTU decode. 0: those encodings are illegal.
//   CNT_W   illegal_count width.
//
// Ports:
//   clk            single clock. All state updates on the rising edge.
//   rst            synchronous, active-high reset. Overrides everything.
//   flush          synchronous flush. Empties the FIFO and drops any
//                  push or pop in the same cycle.
//   in_valid       upstream decode fields are valid.
//   in_ready       FIFO can accept an entry. Depends only on the occupancy.
//   ALUOp, funct3, funct7, op   instruction fields.
//   out_valid      head entry valid (FIFO not empty).
//   out_ready      downstream accepts the head entry.
//   ALUControl     decoded ALU operation of the head entry (registered).
//   illegal        head entry was an unsupported encoding (registered).
//   illegal_count  saturating count of accepted illegal entries.
// -----------------------------------------------------------------------------
module alu_decode_stage #(
    parameter int CTRL_W = 4,
    parameter int EXT_EN = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ALUOp,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [6:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_count
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] F7_BASE  = 7'h00;
    localparam logic [6:0] F7_ALT   = 7'h20;

    // -------------------------------------------------------------------------
    // Combinational decode of the incoming fields
    // -------------------------------------------------------------------------
    alu_ctrl_e w_dec_ctrl;
    logic      w_dec_legal;
    logic      w_dec_ext;
    logic      w_dec_illegal;
    alu_ctrl_e w_push_ctrl;

    always_comb begin
        // NOTE: every variable assigned in this block gets a default first, so
        // no path through the case statements can leave one unassigned and
        // infer a latch.
        w_dec_ctrl  = ALU_ADD;
        w_dec_legal = 1'b0;

        case (ALUOp)
            2'b00: begin
                w_dec_ctrl  = ALU_ADD;
                w_dec_legal = 1'b1;
            end
            2'b01: begin
                w_dec_ctrl  = ALU_SUB;
                w_dec_legal = 1'b1;
            end
            2'b10: begin
                if (op == OP_RTYPE) begin
                    w_dec_legal = 1'b1;
                    case ({funct7, funct3})
                        {F7_BASE, 3'b000}: w_dec_ctrl = ALU_ADD;
                        {F7_ALT,  3'b000}: w_dec_ctrl = ALU_SUB;
                        {F7_BASE, 3'b111}: w_dec_ctrl = ALU_AND;
                        {F7_BASE, 3'b110}: w_dec_ctrl = ALU_OR;
                        {F7_BASE, 3'b100}: w_dec_ctrl = ALU_XOR;
                        {F7_BASE, 3'b001}: w_dec_ctrl = ALU_SLL;
                        {F7_BASE, 3'b101}: w_dec_ctrl = ALU_SRL;
                        {F7_ALT,  3'b101}: w_dec_ctrl = ALU_SRA;
                        {F7_BASE, 3'b010}: w_dec_ctrl = ALU_SLT;
                        {F7_BASE, 3'b011}: w_dec_ctrl = ALU_SLTU;
                        default:           w_dec_legal = 1'b0;
                    endcase
                end else if (op == OP_ITYPE) begin
                    // Immediate forms ignore funct7 except for the shifts,
                    // where it selects logical vs arithmetic right shift.
                    w_dec_legal = 1'b1;
                    case (funct3)
                        3'b000: w_dec_ctrl = ALU_ADD;
                        3'b111: w_dec_ctrl = ALU_AND;
                        3'b110: w_dec_ctrl = ALU_OR;
                        3'b100: w_dec_ctrl = ALU_XOR;
                        3'b010: w_dec_ctrl = ALU_SLT;
                        3'b011: w_dec_ctrl = ALU_SLTU;
                        3'b001: begin
                            if (funct7 == F7_BASE) w_dec_ctrl  = ALU_SLL;
                            else                   w_dec_legal = 1'b0;
                        end
                        default: begin // 3'b101
                            if (funct7 == F7_BASE)     w_dec_ctrl  = ALU_SRL;
                            else if (funct7 == F7_ALT) w_dec_ctrl  = ALU_SRA;
                            else                       w_dec_legal = 1'b0;
                        end
                    endcase
                end
            end
            default: w_dec_legal = 1'b0;
        endcase
    end

    // Shift and compare operations are only supported in the extended build.
    assign w_dec_ext     = (w_dec_ctrl inside {ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU});
    assign w_dec_illegal = !w_dec_legal || ((EXT_EN == 0) && w_dec_ext);
    assign w_push_ctrl   = w_dec_illegal ? ALU_ADD : w_dec_ctrl;

    // -------------------------------------------------------------------------
    // 2-entry FIFO: a head register drives the outputs directly, and a tail
    // register holds the second entry. The head only changes when a new entry
    // becomes the head, so it holds its last value while the FIFO is empty.
    // -------------------------------------------------------------------------
    logic [1:0] r_count;
    alu_ctrl_e  r_head_ctrl;
    logic       r_head_ill;
    alu_ctrl_e  r_tail_ctrl;
    logic       r_tail_ill;
    logic [CNT_W-1:0] r_illegal_count;

    logic w_push;
    logic w_pop;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_count     <= 2'd0;
            r_head_ctrl <= ALU_ADD;
            r_head_ill  <= 1'b0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_ctrl <= w_push_ctrl;
                        r_head_ill  <= w_dec_illegal;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head_ctrl <= r_tail_ctrl;
                        r_head_ill  <= r_tail_ill;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Push needs count<2 and pop needs count>0, so the FIFO
                    // holds exactly one entry: the new entry replaces it.
                    r_head_ctrl <= w_push_ctrl;
                    r_head_ill  <= w_dec_illegal;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the tail entry is pure data storage and has no reset; it is only
    // observed after being written, because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push && !w_pop && (r_count == 2'd1)) begin
            r_tail_ctrl <= w_push_ctrl;
            r_tail_ill  <= w_dec_illegal;
        end
    end

    // Saturating illegal-entry counter. Pushes dropped by a flush do not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_count <= '0;
        end else if (!flush && w_push && w_dec_illegal &&
                     (r_illegal_count != {CNT_W{1'b1}})) begin
            r_illegal_count <= r_illegal_count + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all driven from registers
    // -------------------------------------------------------------------------
    always_comb begin
        ALUControl      = '0;
        ALUControl[3:0] = r_head_ctrl;
    end

    assign illegal       = r_head_ill;
    assign illegal_count = r_illegal_count;

endmodule

// File: tb/tb_alu_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_decode_stage
//
// Two instances share all inputs: dut_a uses default parameters, dut_b is a
// reduced build (EXT_EN=0, CNT_W=2, CTRL_W=5). Flow control does not depend
// on decode, so both FIFOs move in lockstep and one scoreboard queue carries
// the expected decode of each entry for both builds.
// -----------------------------------------------------------------------------
module tb_alu_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [6:0] op;

    logic       a_in_ready, a_out_valid, a_illegal;
    logic [3:0] a_ctrl;
    logic [7:0] a_cnt;
    logic       b_in_ready, b_out_valid, b_illegal;
    logic [4:0] b_ctrl;
    logic [1:0] b_cnt;

    alu_decode_stage dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .ALUOp(alu_op), .funct3(funct3), .funct7(funct7), .op(op),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .ALUControl(a_ctrl), .illegal(a_illegal), .illegal_count(a_cnt)
    );

    alu_decode_stage #(.CTRL_W(5), .EXT_EN(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .ALUOp(alu_op), .funct3(funct3), .funct7(funct7), .op(op),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .ALUControl(b_ctrl), .illegal(b_illegal), .illegal_count(b_cnt)
    );

    typedef struct {
        logic [3:0] ca;
        logic       ia;
        logic [3:0] cb;
        logic       ib;
    } entry_t;

    entry_t sb[$];
    int unsigned m_cnt_a;
    int unsigned m_cnt_b;
    int n_checks = 0;
    int n_fail   = 0;

    // {funct7, funct3, code} for every legal R-type pair.
    logic [13:0] r_tab [10] = '{
        {7'h00, 3'b000, 4'd0}, {7'h20, 3'b000, 4'd1}, {7'h00, 3'b111, 4'd2},
        {7'h00, 3'b110, 4'd3}, {7'h00, 3'b100, 4'd4}, {7'h00, 3'b001, 4'd5},
        {7'h00, 3'b101, 4'd6}, {7'h20, 3'b101, 4'd7}, {7'h00, 3'b010, 4'd8},
        {7'h00, 3'b011, 4'd9}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] ao, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [6:0] opc,
                                       input bit ext, output logic [3:0] code,
                                       output logic ill);
        logic [3:0] c;
        bit ok;
        c  = 4'd0;
        ok = 1'b0;
        if (ao == 2'b00) begin
            c = 4'd0; ok = 1'b1;
        end else if (ao == 2'b01) begin
            c = 4'd1; ok = 1'b1;
        end else if (ao == 2'b10 && opc == 7'b0110011) begin
            foreach (r_tab[i]) begin
                if (r_tab[i][13:7] == f7 && r_tab[i][6:4] == f3) begin
                    c = r_tab[i][3:0]; ok = 1'b1;
                end
            end
        end else if (ao == 2'b10 && opc == 7'b0010011) begin
            ok = 1'b1;
            if      (f3 == 3'b000) c = 4'd0;
            else if (f3 == 3'b111) c = 4'd2;
            else if (f3 == 3'b110) c = 4'd3;
            else if (f3 == 3'b100) c = 4'd4;
            else if (f3 == 3'b010) c = 4'd8;
            else if (f3 == 3'b011) c = 4'd9;
            else if (f3 == 3'b001 && f7 == 7'h00) c = 4'd5;
            else if (f3 == 3'b101 && f7 == 7'h00) c = 4'd6;
            else if (f3 == 3'b101 && f7 == 7'h20) c = 4'd7;
            else ok = 1'b0;
        end
        // Codes 5..9 are the shift/compare group.
        if (ok && !ext && c >= 4'd5) ok = 1'b0;
        code = ok ? c : 4'd0;
        ill  = !ok;
    endfunction

    task automatic set_fields(input logic [1:0] ao, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [6:0] opc);
        alu_op = ao; funct3 = f3; funct7 = f7; op = opc;
    endtask

    // One clock cycle: compare outputs against the model at the falling
    // edge, advance the model with this cycle's inputs, cross the rising
    // edge and return 1 time unit after it.
    task automatic step();
        entry_t e;
        bit do_push;
        bit do_pop;
        @(negedge clk);
        if (!rst) begin
            check("a_out_valid", 32'(a_out_valid), 32'(sb.size() != 0));
            check("a_in_ready",  32'(a_in_ready),  32'(sb.size() < 2));
            check("b_out_valid", 32'(b_out_valid), 32'(sb.size() != 0));
            check("b_in_ready",  32'(b_in_ready),  32'(sb.size() < 2));
            check("a_illegal_count", 32'(a_cnt), m_cnt_a);
            check("b_illegal_count", 32'(b_cnt), m_cnt_b);
            if (out_ready && sb.size() != 0) begin
                check("a_ALUControl", 32'(a_ctrl),    32'(sb[0].ca));
                check("a_illegal",    32'(a_illegal), 32'(sb[0].ia));
                check("b_ALUControl", 32'(b_ctrl),    32'({1'b0, sb[0].cb}));
                check("b_illegal",    32'(b_illegal), 32'(sb[0].ib));
            end
        end
        do_push = in_valid && (sb.size() < 2);
        do_pop  = out_ready && (sb.size() != 0);
        if (rst) begin
            sb.delete();
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (flush) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                ref_decode(alu_op, funct3, funct7, op, 1'b1, e.ca, e.ia);
                ref_decode(alu_op, funct3, funct7, op, 1'b0, e.cb, e.ib);
                sb.push_back(e);
                if (e.ia && m_cnt_a < 255) m_cnt_a++;
                if (e.ib && m_cnt_b < 3)   m_cnt_b++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_a_ALUControl", 32'(a_ctrl), 32'd0);
        check("rst_a_illegal",    32'(a_illegal), 32'd0);
        check("rst_a_count",      32'(a_cnt), 32'd0);
        check("rst_a_out_valid",  32'(a_out_valid), 32'd0);
        check("rst_a_in_ready",   32'(a_in_ready), 32'd1);
        check("rst_b_ALUControl", 32'(b_ctrl), 32'd0);
        check("rst_b_illegal",    32'(b_illegal), 32'd0);
        check("rst_b_count",      32'(b_cnt), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(2'b00, 3'b000, 7'h00, 7'h00);
        m_cnt_a = 0; m_cnt_b = 0;

        // Reset
        step();
        step();
        rst = 1'b0;
        check_reset_outputs();
        step();

        // R-type sweep with a free-flowing consumer, then the illegal pair
        out_ready = 1'b1;
        in_valid  = 1'b1;
        foreach (r_tab[i]) begin
            set_fields(2'b10, r_tab[i][6:4], r_tab[i][13:7], 7'b0110011);
            step();
        end
        set_fields(2'b10, 3'b111, 7'h20, 7'b0110011);
        step();
        in_valid = 1'b0;
        step();
        check("sweep_a_illegal_count", 32'(a_cnt), 32'd1);

        // I-type, fixed ALUOp values, and non-ALU opcode
        in_valid = 1'b1;
        for (int f3 = 0; f3 < 8; f3++) begin
            set_fields(2'b10, 3'(f3), 7'h00, 7'b0010011); step();
            set_fields(2'b10, 3'(f3), 7'h20, 7'b0010011); step();
            set_fields(2'b10, 3'(f3), 7'h01, 7'b0010011); step();
        end
        set_fields(2'b00, 3'b101, 7'h55, 7'h7f); step();
        set_fields(2'b01, 3'b001, 7'h20, 7'h00); step();
        set_fields(2'b11, 3'b000, 7'h00, 7'b0110011); step();
        set_fields(2'b10, 3'b000, 7'h00, 7'b0000011); step();
        in_valid = 1'b0;
        step();

        // Backpressure: three entries offered with the consumer stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_fields(2'b10, 3'b111, 7'h00, 7'b0110011); step();
        set_fields(2'b10, 3'b000, 7'h20, 7'b0110011); step();
        set_fields(2'b10, 3'b100, 7'h00, 7'b0010011); step();
        check("bp_in_ready_full", 32'(a_in_ready), 32'd0);
        step();
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();

        // Flush: full FIFO with a pending push, then flush of a single entry
        // with a concurrent push and pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_fields(2'b01, 3'b000, 7'h00, 7'h00); step();
        set_fields(2'b11, 3'b000, 7'h00, 7'h00); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(a_out_valid), 32'd0);
        check("flush_in_ready",  32'(a_in_ready), 32'd1);
        step();
        in_valid = 1'b1;
        step();
        flush = 1'b1; out_ready = 1'b1;
        set_fields(2'b11, 3'b000, 7'h00, 7'h00);
        step();
        flush = 1'b0; in_valid = 1'b0;
        step();

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            alu_op    = 2'($urandom_range(0, 3));
            funct3    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       funct7 = 7'h00;
                1:       funct7 = 7'h20;
                default: funct7 = 7'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0:       op = 7'b0110011;
                1:       op = 7'b0010011;
                default: op = 7'($urandom);
            endcase
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();

        // Saturation: fresh counters, five illegal pushes
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b1;
        set_fields(2'b11, 3'b000, 7'h00, 7'h00);
        for (int n = 0; n < 5; n++) step();
        in_valid = 1'b0;
        step();
        check("sat_b_count", 32'(b_cnt), 32'd3);
        check("sat_a_count", 32'(a_cnt), 32'd5);

        // Reset mid-operation with a full FIFO and a concurrent push/pop/flush
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_fields(2'b10, 3'b101, 7'h20, 7'b0010011);
        step();
        step();
        check("pre_rst_full", 32'(a_in_ready), 32'd0);
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check_reset_outputs();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 4, ALUControl width; legal values >= 4, upper bits above bit 3 driven 0.
REQ-002 The block SHALL have parameter EXT_EN, default 1; 1 enables shift/SLT/SLTU decode, 0 flags those encodings illegal.
REQ-003 The block SHALL have parameter CNT_W, default 8, illegal-event counter width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 The block SHALL have port flush, input, 1, synchronous pipeline flush.
REQ-007 The block SHALL have port in_valid, input, 1, upstream decode fields valid.
REQ-008 The block SHALL have port in_ready, output, 1, block accepts input this cycle.
REQ-009 The block SHALL have ports ALUOp (input, 2), funct3 (input, 3), funct7 (input, 7) and op (input, 7), instruction fields.
REQ-010 The block SHALL have port out_valid, output, 1, head entry valid.
REQ-011 The block SHALL have port out_ready, input, 1, downstream (EX) accepts head.
REQ-012 The block SHALL have port ALUControl, output, CTRL_W, decoded ALU operation of the head entry.
REQ-013 The block SHALL have port illegal, output, 1, head entry was an unsupported encoding.
REQ-014 The block SHALL have port illegal_count, output, CNT_W, saturating count of illegal entries accepted.

Function
REQ-015 The block SHALL use codes ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110, SRA=0111, SLT=1000, SLTU=1001.
REQ-016 ALUOp=00 SHALL decode ADD and ALUOp=01 SHALL decode SUB, fields ignored, never illegal.
REQ-017 ALUOp=10 with op=0110011 (R-type) SHALL decode on {funct7,funct3}: 0x00/000 ADD, 0x20/000 SUB, 0x00/111 AND, 0x00/110 OR, 0x00/100 XOR, 0x00/001 SLL, 0x00/101 SRL, 0x20/101 SRA, 0x00/010 SLT, 0x00/011 SLTU.
REQ-018 ALUOp=10 with op=0010011 (I-type) SHALL decode funct3 alone for 000/111/110/100/010/011 (ADD/AND/OR/XOR/SLT/SLTU); 001 needs funct7=0x00 (SLL); 101 needs funct7=0x00 (SRL) or 0x20 (SRA).
REQ-019 Any other combination, ALUOp=11, or any SLL/SRL/SRA/SLT/SLTU result when EXT_EN=0, SHALL be illegal: ALUControl=ADD, illegal=1.
REQ-020 The block SHALL hold decoded results in a 2-entry FIFO; in_ready = (count<2), combinational from count only.
REQ-021 Push SHALL occur when in_valid&&in_ready; pop when out_valid&&out_ready; out_valid = (count!=0).
REQ-022 Latency SHALL be one cycle: entry pushed at edge N appears at outputs after edge N, out_valid high in cycle N+1.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, order preserved (FIFO).
REQ-024 Full (count=2): in_ready=0, inputs ignored; empty: ALUControl/illegal hold last value, don't-care to consumers.
REQ-025 flush=1 SHALL set count=0 at the edge, discard any concurrent push and pop; illegal_count unchanged.
REQ-026 illegal_count SHALL increment by 1 per accepted illegal push (not on flush-dropped pushes), saturating at 2^CNT_W-1.
REQ-027 Outputs SHALL be registered; no combinational path from instruction fields to outputs.

Reset
REQ-028 rst=1 at an edge SHALL set count=0, out_valid=0, ALUControl=0, illegal=0, illegal_count=0; in_ready=1 the following cycle.
REQ-029 rst SHALL override flush, push and pop in the same cycle, including mid-transfer with a full FIFO.

Verification
REQ-030 Decode sweep: ALUOp=10, op=0110011, each REQ-017 pair with out_ready=1 -> matching code, illegal=0, one-cycle latency; funct7=0x20/funct3=111 -> ADD, illegal=1, count=1.
REQ-031 Backpressure: out_ready=0, push 3 entries -> in_ready low after 2, third held; release -> entries drain in order, third accepted.
REQ-032 Flush: FIFO full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, pushed entry absent.
REQ-033 EXT_EN=0 build: I-type funct3=001 funct7=0x00 -> ADD, illegal=1; ALUOp=01 -> SUB, illegal=0.
REQ-034 Saturation: CNT_W=2, push 5 illegal entries -> illegal_count 1,2,3,3,3.
REQ-035 Reset mid-operation: count=2, illegal_count=5, rst=1 with push and pop -> all outputs zero, in_ready=1 next cycle.
